// File: rtl/control_sequencer.sv
// Moore timing/control sequencer: fetch T0-T2, execute T3-T7, HALTED on halt/stop.
// Optional ILLEGAL_TRAP_EN: undefined opcodes trap to HALTED and raise `illegal`.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  ALU_op,
`ifdef ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic        Run
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

  state_t     state, next_state;
  logic [3:0] wait_cnt, next_cnt;
  logic [4:0] opcode;
  logic       boundary;
  logic       known_op;
  logic       trap;
  logic       illegal_flag;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign known_op  = (opcode inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                     OP_ADDI, OP_ANDI, OP_ORI, OP_NOP, OP_HALT});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= T0;
      wait_cnt     <= 4'd0;
      illegal_flag <= 1'b0;
    end else begin
      state        <= next_state;
      wait_cnt     <= next_cnt;
      if (trap)
        illegal_flag <= 1'b1;
    end
  end

  // Every path back to T0 is an instruction boundary; stop diverts it to HALTED.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    boundary   = 1'b0;
    trap       = 1'b0;
    case (state)
      T0: begin
        next_state = T1;
        next_cnt   = WAIT_LOAD;
      end
      T1: begin
        if (wait_cnt == 4'd0) next_state = T2;
        else                  next_cnt   = wait_cnt - 4'd1;
      end
      T2: begin
        if (opcode == OP_HALT)      next_state = HALTED;
        else if (opcode == OP_NOP)  boundary   = 1'b1;
        else if (known_op)          next_state = T3;
        else begin
`ifdef ILLEGAL_TRAP_EN
          next_state = HALTED;
          trap       = 1'b1;
`else
          boundary   = 1'b1;
`endif
        end
      end
      T3: next_state = T4;
      T4: next_state = T5;
      T5: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          next_state = T6;
          next_cnt   = WAIT_LOAD;
        end else
          boundary = 1'b1;
      end
      T6: begin
        if (opcode == OP_ST) begin
          next_state = T7;
          next_cnt   = WAIT_LOAD;
        end else if (wait_cnt == 4'd0) next_state = T7;
        else                           next_cnt   = wait_cnt - 4'd1;
      end
      T7: begin
        if (opcode == OP_ST && wait_cnt != 4'd0) next_cnt = wait_cnt - 4'd1;
        else                                     boundary = 1'b1;
      end
      HALTED: next_state = HALTED;
      default: next_state = T0;
    endcase
    if (boundary)
      next_state = stop ? HALTED : T0;
  end

  // Outputs decode state/IR only; reset forces them all low asynchronously.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = 7'b0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout} = 10'b0;
    {Read, Write} = 2'b0;
    ALU_op = 4'd0;
    Run    = 1'b0;
    if (!reset) begin
      Run = (state != HALTED);
      case (state)
        T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
        T1: begin
          {Zlowout, Read, MDRin} = 3'b111;
          PCin = (wait_cnt == WAIT_LOAD);
        end
        T2: {MDRout, IRin} = 2'b11;
        T3: begin
          {Grb, Rout, Yin} = 3'b111;
          BAout = (opcode == OP_LDI || opcode == OP_LD || opcode == OP_ST);
        end
        T4: begin
          Zin = 1'b1;
          if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) {Grc, Rout} = 2'b11;
          else                                               Cout = 1'b1;
          case (opcode)
            OP_SUB:          ALU_op = 4'd1;
            OP_AND, OP_ANDI: ALU_op = 4'd2;
            OP_OR, OP_ORI:   ALU_op = 4'd3;
            default:         ALU_op = 4'd0;
          endcase
        end
        T5: begin
          Zlowout = 1'b1;
          if (opcode == OP_LD || opcode == OP_ST) MARin = 1'b1;
          else                                    {Gra, Rin} = 2'b11;
        end
        T6: begin
          MDRin = 1'b1;
          if (opcode == OP_ST) {Gra, Rout} = 2'b11;
          else                 Read = 1'b1;
        end
        T7: begin
          if (opcode == OP_ST) Write = 1'b1;
          else                 {MDRout, Gra, Rin} = 3'b111;
        end
        default: Run = 1'b0;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_flag && (state == HALTED) && !reset;
`else
  logic unused_flag;
  assign unused_flag = illegal_flag ^ trap;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: two instances (MEM_WAIT=0 and MEM_WAIT=2).
// Stimulus pushes hand-derived per-cycle strobe vectors; a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam logic [24:0] M_ILL = 25'd1 << 24, M_GRA = 25'd1 << 23, M_GRB = 25'd1 << 22;
  localparam logic [24:0] M_GRC = 25'd1 << 21, M_RIN = 25'd1 << 20, M_ROUT = 25'd1 << 19;
  localparam logic [24:0] M_BAOUT = 25'd1 << 18, M_COUT = 25'd1 << 17, M_PCOUT = 25'd1 << 16;
  localparam logic [24:0] M_PCIN = 25'd1 << 15, M_INCPC = 25'd1 << 14, M_MARIN = 25'd1 << 13;
  localparam logic [24:0] M_MDRIN = 25'd1 << 12, M_MDROUT = 25'd1 << 11, M_IRIN = 25'd1 << 10;
  localparam logic [24:0] M_YIN = 25'd1 << 9, M_ZIN = 25'd1 << 8, M_ZLOW = 25'd1 << 7;
  localparam logic [24:0] M_READ = 25'd1 << 6, M_WRITE = 25'd1 << 5, M_RUN = 25'd1;
  localparam logic [24:0] A_SUB = 25'd2, A_AND = 25'd4, A_OR = 25'd6;

  localparam logic [24:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [24:0] E_T1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [24:0] E_T1W = M_ZLOW | M_READ | M_MDRIN | M_RUN;
  localparam logic [24:0] E_T2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [24:0] E_RR3 = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [24:0] E_BA3 = M_GRB | M_ROUT | M_BAOUT | M_YIN | M_RUN;
  localparam logic [24:0] E_RR4 = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [24:0] E_CI4 = M_COUT | M_ZIN | M_RUN;
  localparam logic [24:0] E_WB5 = M_ZLOW | M_GRA | M_RIN | M_RUN;
  localparam logic [24:0] E_MA5 = M_ZLOW | M_MARIN | M_RUN;

  localparam logic [31:0] I_LD = 32'h00440000, I_LDI = 32'h08C40010, I_ST = 32'h10440008;
  localparam logic [31:0] I_ADD = 32'h18A60000, I_SUB = 32'h20A60000, I_AND = 32'h28A60000;
  localparam logic [31:0] I_ORI = 32'h70A6000F, I_NOP = 32'hD0000000, I_HALT = 32'hD8000000;
  localparam logic [31:0] I_ILL = 32'hF8000000;

  typedef struct {
    logic [24:0] vec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic        clock = 1'b0;
  logic        reset0, reset2, stop, sel;
  logic [31:0] ir;

  logic gra0, grb0, grc0, rin0, rout0, baout0, cout0, pcout0, pcin0, incpc0, marin0;
  logic mdrin0, mdrout0, irin0, yin0, zin0, zlow0, read0, write0, run0, ill0;
  logic gra2, grb2, grc2, rin2, rout2, baout2, cout2, pcout2, pcin2, incpc2, marin2;
  logic mdrin2, mdrout2, irin2, yin2, zin2, zlow2, read2, write2, run2, ill2;
  logic [3:0]  alu0, alu2;
  logic [24:0] vec0, vec2;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(0)) dut0 (
    .clock(clock), .reset(reset0), .stop(stop), .IR(ir),
    .Gra(gra0), .Grb(grb0), .Grc(grc0), .Rin(rin0), .Rout(rout0), .BAout(baout0), .Cout(cout0),
    .PCout(pcout0), .PCin(pcin0), .IncPC(incpc0), .MARin(marin0), .MDRin(mdrin0),
    .MDRout(mdrout0), .IRin(irin0), .Yin(yin0), .Zin(zin0), .Zlowout(zlow0),
    .Read(read0), .Write(write0), .ALU_op(alu0),
`ifdef ILLEGAL_TRAP_EN
    .illegal(ill0),
`endif
    .Run(run0)
  );

  control_sequencer #(.MEM_WAIT(2)) dut2 (
    .clock(clock), .reset(reset2), .stop(stop), .IR(ir),
    .Gra(gra2), .Grb(grb2), .Grc(grc2), .Rin(rin2), .Rout(rout2), .BAout(baout2), .Cout(cout2),
    .PCout(pcout2), .PCin(pcin2), .IncPC(incpc2), .MARin(marin2), .MDRin(mdrin2),
    .MDRout(mdrout2), .IRin(irin2), .Yin(yin2), .Zin(zin2), .Zlowout(zlow2),
    .Read(read2), .Write(write2), .ALU_op(alu2),
`ifdef ILLEGAL_TRAP_EN
    .illegal(ill2),
`endif
    .Run(run2)
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill0 = 1'b0;
  assign ill2 = 1'b0;
`endif

  assign vec0 = {ill0, gra0, grb0, grc0, rin0, rout0, baout0, cout0, pcout0, pcin0, incpc0, marin0,
                 mdrin0, mdrout0, irin0, yin0, zin0, zlow0, read0, write0, alu0, run0};
  assign vec2 = {ill2, gra2, grb2, grc2, rin2, rout2, baout2, cout2, pcout2, pcin2, incpc2, marin2,
                 mdrin2, mdrout2, irin2, yin2, zin2, zlow2, read2, write2, alu2, run2};

  task automatic checkOutput(input logic [24:0] actual, input exp_t e);
    checks++;
    if (actual !== e.vec) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", e.tag, actual, e.vec);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(sel ? vec2 : vec0, e);
    end
  end

  task automatic expectNow(input logic [24:0] e, input string tag);
    sb.push_back('{vec: e, tag: tag});
  endtask

  task automatic applyStimulus(input logic [24:0] e, input string tag);
    @(posedge clock);
    #1;
    expectNow(e, tag);
  endtask

  // Fetch phases; IR is presented during T0 so it is stable well before the T2 decode.
  task automatic fetch(input logic [31:0] instr, input int waits, input bit at_t0, input string tag);
    if (at_t0) expectNow(E_T0, {tag, "_T0"});
    else       applyStimulus(E_T0, {tag, "_T0"});
    ir = instr;
    applyStimulus(E_T1, {tag, "_T1"});
    for (int i = 0; i < waits; i++) applyStimulus(E_T1W, {tag, "_T1wait"});
    applyStimulus(E_T2, {tag, "_T2"});
  endtask

  task automatic pulseReset0;
    @(posedge clock); #1 reset0 = 1'b1;
    expectNow(25'd0, "reset0_pulse");
    @(posedge clock); #1 reset0 = 1'b0;
  endtask

  initial begin
    reset0 = 1'b1; reset2 = 1'b1; stop = 1'b0; sel = 1'b0; ir = 32'd0;
    applyStimulus(25'd0, "reset_held");
    @(posedge clock); #1 reset0 = 1'b0;

    fetch(I_ADD, 0, 1'b1, "add");
    applyStimulus(E_RR3, "add_T3");
    applyStimulus(E_RR4, "add_T4");
    applyStimulus(E_WB5, "add_T5");

    fetch(I_AND, 0, 1'b0, "and");
    applyStimulus(E_RR3, "and_T3");
    applyStimulus(E_RR4 | A_AND, "and_T4");
    applyStimulus(E_WB5, "and_T5");

    fetch(I_SUB, 0, 1'b0, "sub");
    applyStimulus(E_RR3, "sub_T3");
    applyStimulus(E_RR4 | A_SUB, "sub_T4");
    stop = 1'b1;
    applyStimulus(E_WB5, "sub_T5_with_stop");
    applyStimulus(25'd0, "stop_halted");
    stop = 1'b0;
    applyStimulus(25'd0, "halted_holds");

    pulseReset0();
    fetch(I_HALT, 0, 1'b1, "halt");
    applyStimulus(25'd0, "halt_halted");
    applyStimulus(25'd0, "halt_holds");

    pulseReset0();
    fetch(I_ORI, 0, 1'b1, "ori");
    applyStimulus(E_RR3, "ori_T3");
    applyStimulus(E_CI4 | A_OR, "ori_T4");
    applyStimulus(E_WB5, "ori_T5");
    fetch(I_NOP, 0, 1'b0, "nop");
    fetch(I_ILL, 0, 1'b0, "illop");
`ifdef ILLEGAL_TRAP_EN
    applyStimulus(M_ILL, "illop_trap");
    applyStimulus(M_ILL, "illop_trap_holds");
    pulseReset0();
    fetch(I_LDI, 0, 1'b1, "ldi");
`else
    fetch(I_LDI, 0, 1'b0, "ldi");
`endif
    applyStimulus(E_BA3, "ldi_T3");
    applyStimulus(E_CI4, "ldi_T4");
    applyStimulus(E_WB5, "ldi_T5");

    fetch(I_ST, 0, 1'b0, "st");
    applyStimulus(E_BA3, "st_T3");
    applyStimulus(E_CI4, "st_T4");
    applyStimulus(E_MA5, "st_T5");
    applyStimulus(M_GRA | M_ROUT | M_MDRIN | M_RUN, "st_T6");
    applyStimulus(M_WRITE | M_RUN, "st_T7");
    applyStimulus(E_T0, "st_next_T0");

    @(posedge clock); #1 reset0 = 1'b1; sel = 1'b1;
    expectNow(25'd0, "w2_reset_held");
    @(posedge clock); #1 reset2 = 1'b0;
    fetch(I_LD, 2, 1'b1, "ld_w2");
    applyStimulus(E_BA3, "ld_w2_T3");
    applyStimulus(E_CI4, "ld_w2_T4");
    applyStimulus(E_MA5, "ld_w2_T5");
    for (int i = 0; i < 3; i++) applyStimulus(M_READ | M_MDRIN | M_RUN, "ld_w2_T6");
    applyStimulus(M_MDROUT | M_GRA | M_RIN | M_RUN, "ld_w2_T7");

    fetch(I_LD, 2, 1'b0, "ld_abort");
    applyStimulus(E_BA3, "ld_abort_T3");
    applyStimulus(E_CI4, "ld_abort_T4");
    applyStimulus(E_MA5, "ld_abort_T5");
    applyStimulus(M_READ | M_MDRIN | M_RUN, "ld_abort_T6");
    @(posedge clock); #1 reset2 = 1'b1;
    expectNow(25'd0, "reset_mid_T6");
    @(posedge clock); #1 reset2 = 1'b0;

    fetch(I_ST, 2, 1'b1, "st_w2");
    applyStimulus(E_BA3, "st_w2_T3");
    applyStimulus(E_CI4, "st_w2_T4");
    applyStimulus(E_MA5, "st_w2_T5");
    applyStimulus(M_GRA | M_ROUT | M_MDRIN | M_RUN, "st_w2_T6");
    for (int i = 0; i < 3; i++) applyStimulus(M_WRITE | M_RUN, "st_w2_T7");
    applyStimulus(E_T0, "st_w2_next_T0");

    @(negedge clock); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
